// File: rtl/or_arb_pkg.sv
// Shared types and default sizing for the OR arbiter.
// Holds the transaction FSM state encoding and the default requester/data widths.
package or_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned N_REQ_DEF  = 4;
    localparam int unsigned DATA_W_DEF = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping.
// Returns a one-hot winner and a flag that any request is pending.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] winner,
    output logic             any_req
);

    int unsigned idx;
    logic        found;

    always_comb begin
        winner  = '0;
        found   = 1'b0;
        idx     = 0;
        any_req = |req;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % N_REQ;
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/or_arbiter.sv
// Round-robin arbiter sharing one registered A|B datapath among N_REQ requesters.
// Define OR_ARB_STATS_EN to add the saturating grant_cnt output.
module or_arbiter
    import or_arb_pkg::*;
#(
    parameter int unsigned N_REQ  = N_REQ_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] a_in,
    input  logic [N_REQ*DATA_W-1:0] b_in,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        done,
    output logic [DATA_W-1:0]       y_out,
`ifdef OR_ARB_STATS_EN
    output logic [15:0]             grant_cnt,
`endif
    output logic                    busy
);

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e              state_q, state_d;
    logic [PW-1:0]       rr_ptr_q;
    logic [PW-1:0]       win_idx_q;
    logic [DATA_W-1:0]   op_a_q, op_b_q;
    logic [N_REQ-1:0]    pick;
    logic                any_req;
    logic [PW-1:0]       pick_idx;
    logic [DATA_W-1:0]   pick_a, pick_b;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PW)
    ) u_rr_pick (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .winner  (pick),
        .any_req (any_req)
    );

    always_comb begin
        pick_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick[i]) pick_idx = PW'(i);
        end
        pick_a = a_in[pick_idx*DATA_W +: DATA_W];
        pick_b = b_in[pick_idx*DATA_W +: DATA_W];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; req only matters in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = EXEC;
            EXEC:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q != IDLE);
    end

    // Datapath and arbitration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            done      <= '0;
            y_out     <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            rr_ptr_q  <= '0;
            win_idx_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        gnt       <= pick;
                        op_a_q    <= pick_a;
                        op_b_q    <= pick_b;
                        win_idx_q <= pick_idx;
                    end
                end
                EXEC: begin
                    y_out <= op_a_q | op_b_q;
                    done  <= gnt;
                end
                DONE: begin
                    gnt      <= '0;
                    done     <= '0;
                    rr_ptr_q <= (win_idx_q == PW'(N_REQ - 1)) ? '0 : win_idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef OR_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
        end else if (state_q == IDLE && any_req && grant_cnt != 16'hFFFF) begin
            grant_cnt <= grant_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_or_arbiter.sv
// Directed, table-driven bench for or_arbiter (N_REQ=4, DATA_W=8).
// Define OR_ARB_STATS_EN to also exercise grant_cnt.
module tb_or_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [7:0]  y_out;
    logic        busy;
`ifdef OR_ARB_STATS_EN
    logic [15:0] grant_cnt;
`endif

    int errors = 0;
    int checks = 0;

    or_arbiter #(
        .N_REQ  (4),
        .DATA_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .done      (done),
        .y_out     (y_out),
`ifdef OR_ARB_STATS_EN
        .grant_cnt (grant_cnt),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [7:0] y;
    } vec_t;

    vec_t vecs[6];

    // Per-slot results for the default operands: slot0 81, slot1 7E, slot2 FF, slot3 A5
    localparam logic [31:0] A_DEF = {8'hA0, 8'h0F, 8'h3C, 8'h01};
    localparam logic [31:0] B_DEF = {8'h05, 8'hF0, 8'h42, 8'h80};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        nxt();
        nxt();
        rst_n = 1'b1;
    endtask

    // req is applied at a negedge; checks the grant, done and idle cycles that follow
    task automatic run_txn(input string name, input logic [3:0] r,
                           input logic [3:0] eg, input logic [7:0] ey);
        req = r;
        nxt();
        chk({name, " gnt"}, 32'(gnt), 32'(eg));
        chk({name, " busy"}, 32'(busy), 32'd1);
        req = 4'b0000;
        nxt();
        chk({name, " done"}, 32'(done), 32'(eg));
        chk({name, " y_out"}, 32'(y_out), 32'(ey));
        nxt();
        chk({name, " idle busy"}, 32'(busy), 32'd0);
        chk({name, " idle gnt"}, 32'(gnt), 32'd0);
        chk({name, " idle done"}, 32'(done), 32'd0);
    endtask

    initial begin
        // Expected winners follow rr_ptr from 0 through the sequence
        vecs[0] = '{req: 4'b0100, gnt: 4'b0100, y: 8'hFF};
        vecs[1] = '{req: 4'b0011, gnt: 4'b0001, y: 8'h81};
        vecs[2] = '{req: 4'b0011, gnt: 4'b0010, y: 8'h7E};
        vecs[3] = '{req: 4'b1010, gnt: 4'b1000, y: 8'hA5};
        vecs[4] = '{req: 4'b1001, gnt: 4'b0001, y: 8'h81};
        vecs[5] = '{req: 4'b1000, gnt: 4'b1000, y: 8'hA5};

        req   = '0;
        a_in  = A_DEF;
        b_in  = B_DEF;
        rst_n = 1'b0;
        nxt();
        chk("reset gnt", 32'(gnt), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset y_out", 32'(y_out), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        nxt();
        rst_n = 1'b1;
        nxt();
        chk("idle no req busy", 32'(busy), 32'd0);
        chk("idle no req gnt", 32'(gnt), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].req, vecs[i].gnt, vecs[i].y);
        end

        // Full contention from reset release: rotate 0,1,2,3,0
        rst_n = 1'b0;
        req   = 4'b1111;
        nxt();
        nxt();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            logic [3:0] eg;
            logic [7:0] ey;
            eg = 4'b0001 << (i % 4);
            ey = 8'(A_DEF >> (8 * (i % 4))) | 8'(B_DEF >> (8 * (i % 4)));
            nxt();
            chk($sformatf("rot%0d gnt", i), 32'(gnt), 32'(eg));
            nxt();
            chk($sformatf("rot%0d done", i), 32'(done), 32'(eg));
            chk($sformatf("rot%0d y_out", i), 32'(y_out), 32'(ey));
            if (i == 4) req = 4'b0000;
            nxt();
            chk($sformatf("rot%0d idle", i), 32'(busy), 32'd0);
        end
        nxt();
        chk("rot quiesce busy", 32'(busy), 32'd0);
        chk("y_out hold", 32'(y_out), 32'h81);

        // Operand change and req drop during EXEC (rr_ptr is 1 here)
        req = 4'b0100;
        nxt();
        chk("opchg gnt", 32'(gnt), 32'b0100);
        req  = 4'b0000;
        a_in = 32'h0;
        b_in = 32'h0;
        nxt();
        chk("opchg done", 32'(done), 32'b0100);
        chk("opchg y_out", 32'(y_out), 32'hFF);
        nxt();
        chk("opchg idle", 32'(busy), 32'd0);
        a_in = A_DEF;
        b_in = B_DEF;

        // Reset mid-EXEC (rr_ptr is 3, so req 0010 picks requester 1)
        req = 4'b0010;
        nxt();
        chk("rst gnt before", 32'(gnt), 32'b0010);
        #1 rst_n = 1'b0;
        #1;
        chk("rst async gnt", 32'(gnt), 32'd0);
        chk("rst async done", 32'(done), 32'd0);
        chk("rst async y_out", 32'(y_out), 32'd0);
        chk("rst async busy", 32'(busy), 32'd0);
        req = 4'b0000;
        nxt();
        nxt();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nxt();
            chk($sformatf("rst no done %0d", i), 32'(done), 32'd0);
        end
        run_txn("post rst", 4'b1111, 4'b0001, 8'h81);

`ifdef OR_ARB_STATS_EN
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_txn($sformatf("stat%0d", i), 4'b0100, 4'b0100, 8'hFF);
        end
        chk("grant_cnt 5", 32'(grant_cnt), 32'd5);
        force dut.grant_cnt = 16'hFFFE;
        nxt();
        release dut.grant_cnt;
        for (int i = 0; i < 3; i++) begin
            run_txn($sformatf("sat%0d", i), 4'b0001, 4'b0001, 8'h81);
        end
        chk("grant_cnt sat", 32'(grant_cnt), 32'hFFFF);
`else
        do_reset();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/or_arbiter.md
OR_ARBITER -- requirements
Module: or_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the OR datapath; legal range 2..8.
REQ-002 Parameter DATA_W, default 8: operand and result width in bits.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 req  input  N_REQ  per-requester request level; held high until that requester's done.
REQ-006 a_in  input  N_REQ*DATA_W  flattened A operands; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-007 b_in  input  N_REQ*DATA_W  flattened B operands, same packing as a_in.
REQ-008 gnt  output  N_REQ  one-hot grant, registered.
REQ-009 done  output  N_REQ  one-hot completion pulse, registered.
REQ-010 y_out  output  DATA_W  result A|B of the granted requester, registered.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 The FSM SHALL have three states: IDLE, EXEC and DONE.
REQ-013 IDLE->EXEC on any req bit high:
- winner = first set req bit searching upward from rr_ptr, wrapping N_REQ-1->0
- gnt <= onehot(winner)
- winner's a_in and b_in slices latched into op_a and op_b
REQ-014 IDLE with req all zero SHALL hold state; gnt, done and busy stay 0.
REQ-015 EXEC->DONE unconditionally:
- y_out <= op_a | op_b
- done <= gnt
REQ-016 DONE->IDLE unconditionally:
- gnt and done cleared
- rr_ptr <= (winner+1) mod N_REQ
REQ-017 Latency: req high at edge k gives gnt from k+1, done and y_out valid from k+2 for one cycle, state IDLE again from k+3.
REQ-018 y_out SHALL hold its last result until the next EXEC->DONE transition.
REQ-019 Operands SHALL be sampled only on the IDLE->EXEC edge; later a_in/b_in changes SHALL NOT affect the result.
REQ-020 A req that drops during EXEC or DONE SHALL NOT abort the transaction; done still pulses.
REQ-021 req is ignored in EXEC and DONE; a new arbitration occurs only in IDLE.
REQ-022 With all req high continuously, grants SHALL rotate 0,1,...,N_REQ-1,0 with one grant per 3 cycles, with no starvation.

Reset
REQ-023 While rst_n is low, the following SHALL be 0 asynchronously:
- state (IDLE), rr_ptr, op_a, op_b
- gnt, done, y_out, busy
REQ-024 Reset asserted mid-transaction SHALL abandon it; no done pulse follows reset release.

Configuration
REQ-025 With OR_ARB_STATS_EN defined, output grant_cnt [15:0] SHALL increment on each IDLE->EXEC edge, saturate at 16'hFFFF, and reset to 0.
REQ-026 Without OR_ARB_STATS_EN, grant_cnt and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-027 Package or_arb_pkg SHALL hold:
- the state enum (IDLE=2'd0, EXEC=2'd1, DONE=2'd2)
- the default constants for N_REQ and DATA_W
REQ-028 Sub-module rr_pick SHALL be combinational. It takes req and rr_ptr and returns a one-hot winner plus an any_req flag.

Verification
REQ-029 The bench SHALL cover the following directed scenarios:
- Single requester: N_REQ=4, DATA_W=8, req=4'b0100, a=8'h0F, b=8'hF0 -> gnt=4'b0100 at k+1, done=4'b0100 and y_out=8'hFF at k+2, busy low at k+3.
- Full contention: req=4'b1111 held from reset release -> grant order 0,1,2,3,0; each done 3 cycles apart; y_out per requester correct.
- Pointer wrap: after requester 3 wins, req=4'b1001 -> requester 0 wins.
- Operand change and req drop: a_in changes and req drops during EXEC -> y_out uses the latched operands; done still pulses.
- Reset mid-EXEC: rst_n low for 2 cycles -> all outputs 0 immediately; no done after release; next winner is requester 0.
- Stats (OR_ARB_STATS_EN): 5 transactions -> grant_cnt=5; counter preloaded to 16'hFFFE, then 3 grants -> 16'hFFFF.
